// File: rtl/alu_result_stage.sv
// alu_result_stage: execute->writeback elastic stage behind the ALU.
// Two-entry FIFO with valid/ready handshakes on both sides. The entry at the
// head of the FIFO drives the Out* ports directly from registers.
// Also holds the architectural status flags (Z,N,C,V) and a saturating
// counter of back-pressure cycles.
module alu_result_stage #(
  parameter int WIDTH = 24,
  parameter int RDW   = 4,
  parameter int CNTW  = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] Result,
  input  logic             Zero,
  input  logic             Overflow,
  input  logic             CarryOut,
  input  logic [RDW-1:0]   Rd,
  input  logic             RegWrite,
  input  logic             SetFlags,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutResult,
  output logic [RDW-1:0]   OutRd,
  output logic             OutRegWrite,
  output logic             FlagZ,
  output logic             FlagN,
  output logic             FlagC,
  output logic             FlagV,
  output logic [CNTW-1:0]  StallCount
);

  localparam logic [CNTW-1:0] STALL_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] STALL_MAX = {CNTW{1'b1}};

  // Occupancy: 0, 1 or 2 entries. Head entry is always r_head_*, the second
  // (younger) entry lives in r_tail_* and shifts into the head on a pop.
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_head_res;
  logic [RDW-1:0]   r_head_rd;
  logic             r_head_rw;
  logic [WIDTH-1:0] r_tail_res;
  logic [RDW-1:0]   r_tail_rd;
  logic             r_tail_rw;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_flag_c;
  logic             r_flag_v;
  logic [CNTW-1:0]  r_stall;

  logic w_push;
  logic w_pop;
  logic w_stall;

  // InReady comes only from the registered count, so there is no
  // combinational OutReady->InReady path; a full buffer refuses even if it
  // pops this cycle. A push during Flush is discarded entirely.
  assign InReady  = ~r_count[1];
  assign OutValid = (r_count != 2'd0);
  assign w_push   = InValid & InReady & ~Flush;
  assign w_pop    = OutValid & OutReady;
  assign w_stall  = OutValid & ~OutReady;

  assign OutResult   = r_head_res;
  assign OutRd       = r_head_rd;
  assign OutRegWrite = r_head_rw;
  assign FlagZ       = r_flag_z;
  assign FlagN       = r_flag_n;
  assign FlagC       = r_flag_c;
  assign FlagV       = r_flag_v;
  assign StallCount  = r_stall;

  // FIFO storage and occupancy; head keeps last popped values when empty.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_count    <= 2'd0;
      r_head_res <= '0;
      r_head_rd  <= '0;
      r_head_rw  <= 1'b0;
      r_tail_res <= '0;
      r_tail_rd  <= '0;
      r_tail_rw  <= 1'b0;
    end else if (Flush) begin
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head_res <= Result;
            r_head_rd  <= Rd;
            r_head_rw  <= RegWrite;
            r_count    <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head_res <= Result;
            r_head_rd  <= Rd;
            r_head_rw  <= RegWrite;
          end else if (w_push) begin
            r_tail_res <= Result;
            r_tail_rd  <= Rd;
            r_tail_rw  <= RegWrite;
            r_count    <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_head_res <= r_tail_res;
            r_head_rd  <= r_tail_rd;
            r_head_rw  <= r_tail_rw;
            r_count    <= 2'd1;
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

  // Status flags follow acceptance order; untouched by pops and Flush.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (w_push && SetFlags) begin
      r_flag_z <= Zero;
      r_flag_n <= Result[WIDTH-1];
      r_flag_c <= CarryOut;
      r_flag_v <= Overflow;
    end
  end

  // Saturating back-pressure counter; survives Flush.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_stall <= '0;
    end else if (w_stall && (r_stall != STALL_MAX)) begin
      r_stall <= r_stall + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the stage.
module tb_alu_result_stage;

  localparam int WIDTH = 24;
  localparam int RDW   = 4;
  localparam int CNTW  = 4;
  localparam int SMAX  = (1 << CNTW) - 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [RDW-1:0]   rd;
    logic             rw;
  } ent_t;

  logic             clk = 1'b0;
  logic             Reset, InValid, InReady, Zero, Overflow, CarryOut;
  logic [WIDTH-1:0] Result, OutResult;
  logic [RDW-1:0]   Rd, OutRd;
  logic             RegWrite, SetFlags, Flush, OutValid, OutReady, OutRegWrite;
  logic             FlagZ, FlagN, FlagC, FlagV;
  logic [CNTW-1:0]  StallCount;

  int checks = 0;
  int failures = 0;

  ent_t m_q[$];
  logic m_z, m_n, m_c, m_v;
  int   m_stall;

  alu_result_stage #(.WIDTH(WIDTH), .RDW(RDW), .CNTW(CNTW)) dut (
    .Clock(clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Result(Result), .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut),
    .Rd(Rd), .RegWrite(RegWrite), .SetFlags(SetFlags), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult),
    .OutRd(OutRd), .OutRegWrite(OutRegWrite), .FlagZ(FlagZ), .FlagN(FlagN),
    .FlagC(FlagC), .FlagV(FlagV), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  // One clock: model decides push/pop from its own state before the edge,
  // then applies the effects; inputs change and outputs are sampled 1ns after.
  task automatic tick();
    bit push, pop, stall;
    ent_t e;
    push  = InValid && (m_q.size() < 2) && !Flush;
    pop   = (m_q.size() > 0) && OutReady;
    stall = (m_q.size() > 0) && !OutReady;
    e = '{res: Result, rd: Rd, rw: RegWrite};
    @(posedge clk);
    #1;
    if (Reset) begin
      m_q.delete();
      {m_z, m_n, m_c, m_v} = 4'b0000;
      m_stall = 0;
    end else begin
      if (stall && m_stall < SMAX) m_stall++;
      if (Flush) m_q.delete();
      else begin
        if (pop) void'(m_q.pop_front());
        if (push) begin
          m_q.push_back(e);
          if (SetFlags) begin
            m_z = Zero; m_n = Result[WIDTH-1]; m_c = CarryOut; m_v = Overflow;
          end
        end
      end
    end
  endtask

  task automatic idle_inputs();
    Reset = 0; InValid = 0; Result = '0; Zero = 0; Overflow = 0; CarryOut = 0;
    Rd = '0; RegWrite = 0; SetFlags = 0; Flush = 0; OutReady = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1;
    tick();
    Reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || OutResult !== '0 || OutRd !== '0 ||
        OutRegWrite !== 1'b0 || {FlagZ, FlagN, FlagC, FlagV} !== 4'b0000 || StallCount !== '0) begin
      failures++;
      $display("FAIL reset: valid=%b ready=%b res=%h rd=%h rw=%b flags=%b stall=%0d required 0 1 0 0 0 0000 0",
               OutValid, InReady, OutResult, OutRd, OutRegWrite, {FlagZ, FlagN, FlagC, FlagV}, StallCount);
    end
  endtask

  task automatic test_single();
    do_reset();
    OutReady = 1; InValid = 1; Result = 24'h000005; Rd = 4'd3; RegWrite = 1;
    tick();
    InValid = 0;
    checks++;
    if (OutValid !== 1'b1 || OutResult !== 24'h000005 || OutRd !== 4'd3 || OutRegWrite !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: valid=%b res=%h rd=%0d rw=%b required 1 000005 3 1",
               OutValid, OutResult, OutRd, OutRegWrite);
    end
    tick();
    checks++;
    if (OutValid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain: valid=%b required 0", OutValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] exp_seq[3];
    bit acc;
    exp_seq[0] = 24'h0A0A0A; exp_seq[1] = 24'h0B0B0B; exp_seq[2] = 24'h0C0C0C;
    do_reset();
    OutReady = 0; InValid = 1; RegWrite = 1;
    for (int i = 0; i < 3; i++) begin
      Result = exp_seq[i]; Rd = 4'(i + 1);
      tick();
    end
    checks++;
    if (InReady !== 1'b0 || OutValid !== 1'b1 || OutResult !== exp_seq[0]) begin
      failures++;
      $display("FAIL full_hold: ready=%b valid=%b res=%h required 0 1 %h",
               InReady, OutValid, OutResult, exp_seq[0]);
    end
    OutReady = 1;
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      if (OutValid && OutReady) got.push_back(OutResult);
      acc = InValid && InReady;
      tick();
      if (acc) InValid = 0;
    end
    checks++;
    if (got.size() != 3) begin
      failures++;
      $display("FAIL drain_count: got %0d entries required 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== exp_seq[i]) begin
          failures++;
          $display("FAIL drain_order[%0d]: got %h required %h", i, got[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_flags();
    do_reset();
    OutReady = 1; InValid = 1; SetFlags = 1;
    Result = 24'h800000; CarryOut = 1; Overflow = 1; Zero = 0;
    tick();
    checks++;
    if ({FlagZ, FlagN, FlagC, FlagV} !== 4'b0111) begin
      failures++;
      $display("FAIL flags_set: ZNCV=%b required 0111", {FlagZ, FlagN, FlagC, FlagV});
    end
    SetFlags = 0; Result = '0; CarryOut = 0; Overflow = 0; Zero = 1;
    tick();
    checks++;
    if ({FlagZ, FlagN, FlagC, FlagV} !== 4'b0111) begin
      failures++;
      $display("FAIL flags_hold: ZNCV=%b required 0111", {FlagZ, FlagN, FlagC, FlagV});
    end
    SetFlags = 1;
    tick();
    InValid = 0;
    checks++;
    if ({FlagZ, FlagN, FlagC, FlagV} !== 4'b1000) begin
      failures++;
      $display("FAIL flags_zero: ZNCV=%b required 1000", {FlagZ, FlagN, FlagC, FlagV});
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    OutReady = 0; InValid = 1; Result = 24'd100;
    tick();
    OutReady = 1;
    for (int i = 0; i < 10; i++) begin
      Result = 24'(200 + i);
      tick();
      checks++;
      if (OutValid !== 1'b1 || InReady !== 1'b1 || OutResult !== 24'(200 + i)) begin
        failures++;
        $display("FAIL push_pop[%0d]: valid=%b ready=%b res=%0d required 1 1 %0d",
                 i, OutValid, InReady, OutResult, 200 + i);
      end
    end
    InValid = 0;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    OutReady = 0; InValid = 1; SetFlags = 1;
    Result = 24'h800000; CarryOut = 1; Overflow = 1; Zero = 0;
    tick();
    SetFlags = 0; Result = 24'h000010;
    tick();
    Flush = 1; SetFlags = 1; Result = '0; Zero = 1; CarryOut = 0; Overflow = 0;
    tick();
    Flush = 0;
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || {FlagZ, FlagN, FlagC, FlagV} !== 4'b0111 ||
        StallCount !== CNTW'(m_stall) || m_stall == 0) begin
      failures++;
      $display("FAIL flush_full: valid=%b ready=%b ZNCV=%b stall=%0d required 0 1 0111 %0d",
               OutValid, InReady, {FlagZ, FlagN, FlagC, FlagV}, StallCount, m_stall);
    end
    InValid = 1; SetFlags = 0; Result = 24'h000021;
    tick();
    Flush = 1; SetFlags = 1; Result = '0;
    tick();
    Flush = 0; InValid = 0;
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || {FlagZ, FlagN, FlagC, FlagV} !== 4'b0111) begin
      failures++;
      $display("FAIL flush_drop_push: valid=%b ready=%b ZNCV=%b required 0 1 0111",
               OutValid, InReady, {FlagZ, FlagN, FlagC, FlagV});
    end
    InValid = 1; Result = 24'h000033; Rd = 4'd9; RegWrite = 1;
    tick(); tick();
    Reset = 1;
    tick();
    Reset = 0; InValid = 0;
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || OutResult !== '0 || OutRd !== '0 ||
        OutRegWrite !== 1'b0 || {FlagZ, FlagN, FlagC, FlagV} !== 4'b0000 || StallCount !== '0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b ready=%b res=%h rd=%h rw=%b flags=%b stall=%0d required 0 1 0 0 0 0000 0",
               OutValid, InReady, OutResult, OutRd, OutRegWrite, {FlagZ, FlagN, FlagC, FlagV}, StallCount);
    end
  endtask

  task automatic test_stall_saturate();
    do_reset();
    OutReady = 0; InValid = 1; Result = 24'h00ABCD;
    tick();
    InValid = 0;
    repeat (20) tick();
    checks++;
    if (StallCount !== 4'd15) begin
      failures++;
      $display("FAIL stall_sat: stall=%0d required 15", StallCount);
    end
    repeat (3) tick();
    checks++;
    if (StallCount !== 4'd15 || OutValid !== 1'b1 || OutResult !== 24'h00ABCD) begin
      failures++;
      $display("FAIL stall_hold: stall=%0d valid=%b res=%h required 15 1 00abcd",
               StallCount, OutValid, OutResult);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      InValid  = ($urandom_range(0, 9) < 7);
      OutReady = ($urandom_range(0, 9) < 5);
      Flush    = ($urandom_range(0, 29) == 0);
      Reset    = ($urandom_range(0, 199) == 0);
      SetFlags = $urandom_range(0, 1);
      Zero     = $urandom_range(0, 1);
      Overflow = $urandom_range(0, 1);
      CarryOut = $urandom_range(0, 1);
      RegWrite = $urandom_range(0, 1);
      Result   = WIDTH'($urandom);
      Rd       = RDW'($urandom);
      tick();
      checks++;
      if (OutValid !== (m_q.size() > 0) || InReady !== (m_q.size() < 2) ||
          {FlagZ, FlagN, FlagC, FlagV} !== {m_z, m_n, m_c, m_v} || StallCount !== CNTW'(m_stall)) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: valid=%b ready=%b ZNCV=%b stall=%0d required %b %b %b %0d",
                 c, OutValid, InReady, {FlagZ, FlagN, FlagC, FlagV}, StallCount,
                 m_q.size() > 0, m_q.size() < 2, {m_z, m_n, m_c, m_v}, m_stall);
      end
      if (m_q.size() > 0) begin
        checks++;
        if (OutResult !== m_q[0].res || OutRd !== m_q[0].rd || OutRegWrite !== m_q[0].rw) begin
          failures++;
          $display("FAIL rand_data[%0d]: res=%h rd=%h rw=%b required %h %h %b",
                   c, OutResult, OutRd, OutRegWrite, m_q[0].res, m_q[0].rd, m_q[0].rw);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_stall = 0;
    {m_z, m_n, m_c, m_v} = 4'b0000;
    test_reset();
    test_single();
    test_back_to_back();
    test_flags();
    test_push_pop();
    test_flush();
    test_stall_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
